// File: rtl/resp_chk_pkg.sv
// Shared types and helpers for the response checker: FSM encoding, default
// MISR taps and the MISR next-state function used by the design and its bench.
package resp_chk_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int          MISR_MAX_W   = 64;
  localparam logic [15:0] SIG_POLY_DEF = 16'h8016;

  // Shift left by one, fold the old MSB back through the taps, then XOR in data.
  // Only the low w bits are meaningful; everything above is forced to zero.
  function automatic logic [MISR_MAX_W-1:0] misr_next(
    input logic [MISR_MAX_W-1:0] sig,
    input logic [MISR_MAX_W-1:0] data,
    input logic [MISR_MAX_W-1:0] poly,
    input int                    w
  );
    logic [MISR_MAX_W-1:0] mask;
    logic                  msb;
    mask = '0;
    msb  = 1'b0;
    for (int i = 0; i < MISR_MAX_W; i++) begin
      mask[i] = (i < w);
      if (i == w - 1) begin
        msb = sig[i];
      end
    end
    return ((sig << 1) ^ (msb ? poly : '0) ^ data) & mask;
  endfunction

endpackage

// File: rtl/resp_checker_if.sv
// Paired golden/netlist response stream with valid/ready flow control.
interface resp_checker_if #(
  parameter int WIDTH = 1
) ();
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] golden;
  logic [WIDTH-1:0] dut;

  modport master (output in_valid, golden, dut, input in_ready);
  modport slave  (input in_valid, golden, dut, output in_ready);
endinterface

// File: rtl/resp_misr.sv
// Multiple-input signature register compacting netlist responses.
module resp_misr
  import resp_chk_pkg::*;
#(
  parameter int               SIG_W    = 16,
  parameter logic [SIG_W-1:0] SIG_POLY = SIG_W'(SIG_POLY_DEF)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic [SIG_W-1:0] din,
  output logic [SIG_W-1:0] sig
);

  logic [SIG_W-1:0]      sig_r;
  logic [MISR_MAX_W-1:0] nxt_s;

  assign nxt_s = misr_next(MISR_MAX_W'(sig_r), MISR_MAX_W'(din),
                           MISR_MAX_W'(SIG_POLY), SIG_W);
  assign sig   = sig_r;

  // Clear at the start of a run has priority over compaction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig_r <= '0;
    end else if (clr) begin
      sig_r <= '0;
    end else if (en) begin
      sig_r <= nxt_s[SIG_W-1:0];
    end
  end

endmodule

// File: rtl/resp_checker.sv
// Golden-vs-netlist response checker: counts vectors and mismatches, records
// the first failing index, compacts netlist words and reports a verdict.
module resp_checker
  import resp_chk_pkg::*;
#(
  parameter int               WIDTH    = 1,
  parameter int               CNT_W    = 16,
  parameter int               SIG_W    = 16,
  parameter logic [SIG_W-1:0] SIG_POLY = SIG_W'(SIG_POLY_DEF)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [CNT_W-1:0]   num_vectors,
  resp_checker_if.slave      bus,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [CNT_W-1:0]   vec_cnt,
  output logic [CNT_W-1:0]   mismatch_cnt,
  output logic               first_fail_vld,
  output logic [CNT_W-1:0]   first_fail_idx,
  output logic [SIG_W-1:0]   signature
);

  state_t             state_r;
  logic [CNT_W-1:0]   target_r;
  logic [CNT_W-1:0]   vec_cnt_r;
  logic [CNT_W-1:0]   mismatch_cnt_r;
  logic [CNT_W-1:0]   first_fail_idx_r;
  logic               first_fail_vld_r;
  logic               busy_r;
  logic               done_r;
  logic               pass_r;

  logic               xfer_s;
  logic               mis_s;
  logic               start_ok_s;
  logic [CNT_W-1:0]   vec_inc_s;
  logic [CNT_W-1:0]   mism_nxt_s;

  assign bus.in_ready = (state_r == RUN);

  // Transfer qualification and next-count arithmetic.
  always_comb begin
    xfer_s     = bus.in_valid && (state_r == RUN);
    mis_s      = (bus.golden != bus.dut);
    start_ok_s = start && (state_r != RUN);
    vec_inc_s  = vec_cnt_r + CNT_W'(1);
    if (mis_s && (mismatch_cnt_r != {CNT_W{1'b1}})) begin
      mism_nxt_s = mismatch_cnt_r + CNT_W'(1);
    end else begin
      mism_nxt_s = mismatch_cnt_r;
    end
  end

  // Run-control FSM with counters, first-fail capture and verdict flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r          <= IDLE;
      target_r         <= '0;
      vec_cnt_r        <= '0;
      mismatch_cnt_r   <= '0;
      first_fail_idx_r <= '0;
      first_fail_vld_r <= 1'b0;
      busy_r           <= 1'b0;
      done_r           <= 1'b0;
      pass_r           <= 1'b0;
    end else begin
      case (state_r)
        IDLE, DONE: begin
          if (start) begin
            target_r         <= num_vectors;
            vec_cnt_r        <= '0;
            mismatch_cnt_r   <= '0;
            first_fail_idx_r <= '0;
            first_fail_vld_r <= 1'b0;
            if (num_vectors == '0) begin
              // Empty run completes immediately and trivially passes.
              state_r <= DONE;
              busy_r  <= 1'b0;
              done_r  <= 1'b1;
              pass_r  <= 1'b1;
            end else begin
              state_r <= RUN;
              busy_r  <= 1'b1;
              done_r  <= 1'b0;
              pass_r  <= 1'b0;
            end
          end
        end
        RUN: begin
          if (xfer_s) begin
            vec_cnt_r      <= vec_inc_s;
            mismatch_cnt_r <= mism_nxt_s;
            if (mis_s && !first_fail_vld_r) begin
              first_fail_vld_r <= 1'b1;
              first_fail_idx_r <= vec_cnt_r;
            end
            if (vec_inc_s == target_r) begin
              state_r <= DONE;
              busy_r  <= 1'b0;
              done_r  <= 1'b1;
              pass_r  <= (mism_nxt_s == '0);
            end
          end
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
          pass_r  <= 1'b0;
        end
      endcase
    end
  end

  resp_misr #(
    .SIG_W    (SIG_W),
    .SIG_POLY (SIG_POLY)
  ) u_misr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (start_ok_s),
    .en    (xfer_s),
    .din   (SIG_W'(bus.dut)),
    .sig   (signature)
  );

  assign busy           = busy_r;
  assign done           = done_r;
  assign pass           = pass_r;
  assign vec_cnt        = vec_cnt_r;
  assign mismatch_cnt   = mismatch_cnt_r;
  assign first_fail_vld = first_fail_vld_r;
  assign first_fail_idx = first_fail_idx_r;

endmodule

// File: tb/tb_resp_checker.sv
// Scoreboard bench for resp_checker: a reference model predicts the full
// output state each cycle; predictions are queued and compared after the edge.
module tb_resp_checker;
  import resp_chk_pkg::*;

  typedef struct packed {
    logic        ready;
    logic        busy;
    logic        done;
    logic        pass;
    logic [15:0] vec;
    logic [15:0] mism;
    logic [15:0] sig;
    logic        ffv;
    logic [15:0] ffi;
  } obs_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] num_vectors;
  logic        busy, done, pass, first_fail_vld;
  logic [15:0] vec_cnt, mismatch_cnt, first_fail_idx, signature;

  int total = 0;
  int bad   = 0;

  obs_t sb_q[$];

  logic        m_run, m_done, m_pass, m_ffv;
  logic [15:0] m_tgt, m_vec, m_mism, m_sig, m_ffi;

  resp_checker_if #(.WIDTH(1)) bus ();

  resp_checker #(
    .WIDTH (1),
    .CNT_W (16),
    .SIG_W (16)
  ) dut_i (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .num_vectors    (num_vectors),
    .bus            (bus.slave),
    .busy           (busy),
    .done           (done),
    .pass           (pass),
    .vec_cnt        (vec_cnt),
    .mismatch_cnt   (mismatch_cnt),
    .first_fail_vld (first_fail_vld),
    .first_fail_idx (first_fail_idx),
    .signature      (signature)
  );

  always #5 clk = ~clk;

  function automatic obs_t get_obs();
    return {bus.in_ready, busy, done, pass, vec_cnt, mismatch_cnt,
            signature, first_fail_vld, first_fail_idx};
  endfunction

  task automatic model_clear();
    m_run = 1'b0; m_done = 1'b0; m_pass = 1'b0; m_ffv = 1'b0;
    m_tgt = 16'd0; m_vec = 16'd0; m_mism = 16'd0; m_sig = 16'd0; m_ffi = 16'd0;
  endtask

  // One cycle: drive at negedge, predict, compare #1 after the posedge.
  task automatic send(input logic g, input logic d, input logic v,
                      input logic st, input logic [15:0] nv);
    obs_t        e;
    obs_t        a;
    logic [63:0] tmp;
    bus.in_valid = v; bus.golden = g; bus.dut = d;
    start = st; num_vectors = nv;
    #1;
    total++;
    if (bus.in_ready !== m_run) begin
      bad++;
      $display("FAIL ready_pre: got %b want %b", bus.in_ready, m_run);
    end
    if (st && !m_run) begin
      m_tgt = nv; m_vec = 16'd0; m_mism = 16'd0; m_sig = 16'd0;
      m_ffv = 1'b0; m_ffi = 16'd0;
      m_run  = (nv != 16'd0);
      m_done = (nv == 16'd0);
      m_pass = (nv == 16'd0);
    end else if (v && m_run) begin
      if (g != d) begin
        if (m_mism != 16'hFFFF) m_mism = m_mism + 16'd1;
        if (!m_ffv) begin
          m_ffv = 1'b1;
          m_ffi = m_vec;
        end
      end
      tmp   = misr_next(64'(m_sig), 64'(d), 64'(SIG_POLY_DEF), 16);
      m_sig = tmp[15:0];
      m_vec = m_vec + 16'd1;
      if (m_vec == m_tgt) begin
        m_run  = 1'b0;
        m_done = 1'b1;
        m_pass = (m_mism == 16'd0);
      end
    end
    sb_q.push_back({m_run, m_run, m_done, m_pass, m_vec, m_mism, m_sig, m_ffv, m_ffi});
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    a = get_obs();
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL cycle_state: got %h want %h (rdy,busy,done,pass,vec,mism,sig,ffv,ffi)", a, e);
    end
    start = 1'b0; bus.in_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; num_vectors = 16'd0;
    bus.in_valid = 1'b0; bus.golden = 1'b0; bus.dut = 1'b0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (get_obs() !== obs_t'(0)) begin
      bad++;
      $display("FAIL reset_state: got %h want 0", get_obs());
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_and();
    send(1'b0, 1'b0, 1'b0, 1'b1, 16'd4);
    send(1'b0, 1'b0, 1'b1, 1'b0, 16'd0);
    send(1'b0, 1'b0, 1'b1, 1'b0, 16'd0);
    send(1'b0, 1'b0, 1'b1, 1'b0, 16'd0);
    send(1'b1, 1'b1, 1'b1, 1'b0, 16'd0);
    total++;
    if (done !== 1'b1 || pass !== 1'b1 || vec_cnt !== 16'd4 || mismatch_cnt !== 16'd0) begin
      bad++;
      $display("FAIL and_verdict: got done=%b pass=%b vec=%0d mism=%0d want 1 1 4 0",
               done, pass, vec_cnt, mismatch_cnt);
    end
    send(1'b1, 1'b0, 1'b1, 1'b0, 16'd0);
  endtask

  task automatic test_faults();
    logic g;
    send(1'b0, 1'b0, 1'b0, 1'b1, 16'd8);
    for (int i = 0; i < 8; i++) begin
      g = 1'($urandom_range(0, 1));
      send(g, (i == 2 || i == 5) ? ~g : g, 1'b1, 1'b0, 16'd0);
    end
    total++;
    if (mismatch_cnt !== 16'd2 || first_fail_idx !== 16'd2 ||
        first_fail_vld !== 1'b1 || pass !== 1'b0 || done !== 1'b1) begin
      bad++;
      $display("FAIL fault_verdict: got mism=%0d ffi=%0d ffv=%b pass=%b done=%b want 2 2 1 0 1",
               mismatch_cnt, first_fail_idx, first_fail_vld, pass, done);
    end
  endtask

  task automatic test_stalls();
    logic [5:0] pat;
    pat = 6'b101001;
    send(1'b0, 1'b0, 1'b0, 1'b1, 16'd3);
    for (int i = 0; i < 6; i++) begin
      send(1'b1, 1'b1, pat[i], 1'b0, 16'd0);
    end
    total++;
    if (done !== 1'b1 || vec_cnt !== 16'd3) begin
      bad++;
      $display("FAIL stall_done: got done=%b vec=%0d want 1 3", done, vec_cnt);
    end
  endtask

  task automatic test_misr();
    logic [3:0] seq;
    seq = 4'b1101;
    send(1'b0, 1'b0, 1'b0, 1'b1, 16'd4);
    for (int i = 0; i < 4; i++) begin
      send(seq[i], seq[i], 1'b1, 1'b0, 16'd0);
    end
    total++;
    if (signature !== 16'h000B) begin
      bad++;
      $display("FAIL misr_sig: got %h want 000b", signature);
    end
  endtask

  task automatic test_restart_zero();
    send(1'b0, 1'b0, 1'b0, 1'b1, 16'd0);
    total++;
    if (done !== 1'b1 || pass !== 1'b1 || vec_cnt !== 16'd0 || signature !== 16'd0) begin
      bad++;
      $display("FAIL zero_len: got done=%b pass=%b vec=%0d sig=%h want 1 1 0 0000",
               done, pass, vec_cnt, signature);
    end
    send(1'b0, 1'b0, 1'b0, 1'b1, 16'd3);
    send(1'b1, 1'b0, 1'b1, 1'b0, 16'd0);
    send(1'b0, 1'b0, 1'b1, 1'b1, 16'd7);
    send(1'b1, 1'b1, 1'b1, 1'b0, 16'd0);
    total++;
    if (done !== 1'b1 || vec_cnt !== 16'd3 || first_fail_idx !== 16'd0 || pass !== 1'b0) begin
      bad++;
      $display("FAIL start_in_run: got done=%b vec=%0d ffi=%0d pass=%b want 1 3 0 0",
               done, vec_cnt, first_fail_idx, pass);
    end
  endtask

  task automatic test_reset_mid();
    send(1'b0, 1'b0, 1'b0, 1'b1, 16'd5);
    send(1'b1, 1'b0, 1'b1, 1'b0, 16'd0);
    send(1'b0, 1'b1, 1'b1, 1'b0, 16'd0);
    rst_n = 1'b0;
    #1;
    model_clear();
    total++;
    if (get_obs() !== obs_t'(0)) begin
      bad++;
      $display("FAIL reset_async: got %h want 0", get_obs());
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    total++;
    if (bus.in_ready !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || vec_cnt !== 16'd0) begin
      bad++;
      $display("FAIL reset_release: got rdy=%b busy=%b done=%b vec=%0d want 0 0 0 0",
               bus.in_ready, busy, done, vec_cnt);
    end
    @(negedge clk);
    send(1'b1, 1'b1, 1'b1, 1'b0, 16'd0);
  endtask

  initial begin
    test_reset();
    test_and();
    test_faults();
    test_stalls();
    test_misr();
    test_restart_zero();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
